// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and a
// saturating stall-bubble counter.
module id_ex_stage #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              id_memtoreg,
  input  logic              id_branch,
  input  logic              id_alusrc,
  input  logic [1:0]        id_aluop,
  input  logic              id_valid,
  input  logic              flush,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_memtoreg,
  output logic              ex_branch,
  output logic              ex_alusrc,
  output logic [1:0]        ex_aluop,
  output logic              ex_valid,
  output logic              stall,
  output logic              pc_write,
  output logic              if_id_write,
  output logic [CNT_W-1:0]  stall_count
);

  typedef struct packed {
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic              regwrite;
    logic              memread;
    logic              memwrite;
    logic              memtoreg;
    logic              branch;
    logic              alusrc;
    logic [1:0]        aluop;
    logic              valid;
  } id_ex_t;

  localparam logic [CNT_W-1:0] ONE = 1;

  id_ex_t           r_ex;
  id_ex_t           w_id;
  id_ex_t           w_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             w_ex_load;
  logic             w_src_hit;
  logic             w_hazard;
  logic             w_sat;
  logic             w_cnt_en;

  always_comb begin
    w_id          = '0;
    w_id.rd1      = id_rd1;
    w_id.rd2      = id_rd2;
    w_id.imm      = id_imm;
    w_id.pc       = id_pc;
    w_id.rs1      = id_rs1;
    w_id.rs2      = id_rs2;
    w_id.rd       = id_rd;
    w_id.regwrite = id_regwrite;
    w_id.memread  = id_memread;
    w_id.memwrite = id_memwrite;
    w_id.memtoreg = id_memtoreg;
    w_id.branch   = id_branch;
    w_id.alusrc   = id_alusrc;
    w_id.aluop    = id_aluop;
    w_id.valid    = 1'b1;
  end

  // x0 is hardwired zero, so a load targeting it never blocks
  assign w_ex_load = r_ex.valid & r_ex.memread & (r_ex.rd != 5'd0);
  assign w_src_hit = (r_ex.rd == id_rs1) | (r_ex.rd == id_rs2);
  assign w_hazard  = w_ex_load & id_valid & w_src_hit;

  always_comb begin
    w_nxt = '0;
    if (flush) begin
      w_nxt = '0;
    end else if (w_hazard) begin
      w_nxt = '0;
    end else if (id_valid) begin
      w_nxt = w_id;
    end
  end

  assign w_sat    = &r_cnt;
  assign w_cnt_en = w_hazard & ~flush & ~w_sat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ex  <= '0;
      r_cnt <= '0;
    end else begin
      r_ex <= w_nxt;
      if (w_cnt_en) begin
        r_cnt <= r_cnt + ONE;
      end
    end
  end

  assign ex_rd1      = r_ex.rd1;
  assign ex_rd2      = r_ex.rd2;
  assign ex_imm      = r_ex.imm;
  assign ex_pc       = r_ex.pc;
  assign ex_rs1      = r_ex.rs1;
  assign ex_rs2      = r_ex.rs2;
  assign ex_rd       = r_ex.rd;
  assign ex_regwrite = r_ex.regwrite;
  assign ex_memread  = r_ex.memread;
  assign ex_memwrite = r_ex.memwrite;
  assign ex_memtoreg = r_ex.memtoreg;
  assign ex_branch   = r_ex.branch;
  assign ex_alusrc   = r_ex.alusrc;
  assign ex_aluop    = r_ex.aluop;
  assign ex_valid    = r_ex.valid;
  assign stall       = w_hazard;
  assign pc_write    = ~w_hazard;
  assign if_id_write = ~w_hazard;
  assign stall_count = r_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed vectors, queue of
// expected EX bundles, negedge monitor.
module tb_id_ex_stage;

  typedef struct packed {
    logic [63:0] rd1;
    logic [63:0] rd2;
    logic [63:0] imm;
    logic [63:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [5:0]  ctl;
    logic [1:0]  aluop;
    logic        valid;
  } bun_t;

  typedef struct packed {
    bun_t        b;
    logic [15:0] cnt;
    logic [1:0]  cnts;
  } exp_t;

  // ctl = {regwrite, memread, memwrite, memtoreg, branch, alusrc}
  localparam logic [5:0] C_LD  = 6'b110101;
  localparam logic [5:0] C_ALU = 6'b100000;
  localparam logic [5:0] C_SD  = 6'b001001;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [63:0] id_rd1, id_rd2, id_imm, id_pc;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_regwrite, id_memread, id_memwrite;
  logic        id_memtoreg, id_branch, id_alusrc;
  logic [1:0]  id_aluop;
  logic        id_valid, flush;

  logic [63:0] ex_rd1, ex_rd2, ex_imm, ex_pc;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic        ex_regwrite, ex_memread, ex_memwrite;
  logic        ex_memtoreg, ex_branch, ex_alusrc;
  logic [1:0]  ex_aluop;
  logic        ex_valid, stall, pc_write, if_id_write;
  logic [15:0] stall_count;

  logic [63:0] s_rd1, s_rd2, s_imm, s_pc;
  logic [4:0]  s_rs1, s_rs2, s_rd;
  logic        s_regwrite, s_memread, s_memwrite;
  logic        s_memtoreg, s_branch, s_alusrc;
  logic [1:0]  s_aluop;
  logic        s_valid, s_stall, s_pc_write, s_if_id_write;
  logic [1:0]  s_count;

  id_ex_stage #(.DATA_W(64), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .id_rd1(id_rd1), .id_rd2(id_rd2),
    .id_imm(id_imm), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
    .id_branch(id_branch), .id_alusrc(id_alusrc),
    .id_aluop(id_aluop), .id_valid(id_valid), .flush(flush),
    .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
    .ex_imm(ex_imm), .ex_pc(ex_pc),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
    .ex_branch(ex_branch), .ex_alusrc(ex_alusrc),
    .ex_aluop(ex_aluop), .ex_valid(ex_valid),
    .stall(stall), .pc_write(pc_write),
    .if_id_write(if_id_write), .stall_count(stall_count)
  );

  id_ex_stage #(.DATA_W(64), .CNT_W(2)) dut_s (
    .clk(clk), .reset(reset),
    .id_rd1(id_rd1), .id_rd2(id_rd2),
    .id_imm(id_imm), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
    .id_branch(id_branch), .id_alusrc(id_alusrc),
    .id_aluop(id_aluop), .id_valid(id_valid), .flush(flush),
    .ex_rd1(s_rd1), .ex_rd2(s_rd2),
    .ex_imm(s_imm), .ex_pc(s_pc),
    .ex_rs1(s_rs1), .ex_rs2(s_rs2), .ex_rd(s_rd),
    .ex_regwrite(s_regwrite), .ex_memread(s_memread),
    .ex_memwrite(s_memwrite), .ex_memtoreg(s_memtoreg),
    .ex_branch(s_branch), .ex_alusrc(s_alusrc),
    .ex_aluop(s_aluop), .ex_valid(s_valid),
    .stall(s_stall), .pc_write(s_pc_write),
    .if_id_write(s_if_id_write), .stall_count(s_count)
  );

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  function automatic bun_t dut_bun();
    bun_t b;
    b.rd1   = ex_rd1;
    b.rd2   = ex_rd2;
    b.imm   = ex_imm;
    b.pc    = ex_pc;
    b.rs1   = ex_rs1;
    b.rs2   = ex_rs2;
    b.rd    = ex_rd;
    b.ctl   = {ex_regwrite, ex_memread, ex_memwrite,
               ex_memtoreg, ex_branch, ex_alusrc};
    b.aluop = ex_aluop;
    b.valid = ex_valid;
    return b;
  endfunction

  function automatic bun_t mk(
    logic [63:0] a, logic [63:0] b, logic [63:0] im,
    logic [63:0] pc, logic [4:0] rs1, logic [4:0] rs2,
    logic [4:0] rd, logic [5:0] ctl, logic [1:0] op,
    logic v);
    bun_t r;
    r.rd1 = a;  r.rd2 = b; r.imm = im; r.pc = pc;
    r.rs1 = rs1; r.rs2 = rs2; r.rd = rd;
    r.ctl = ctl; r.aluop = op; r.valid = v;
    return r;
  endfunction

  task automatic apply(bun_t v, logic fl);
    id_rd1 = v.rd1; id_rd2 = v.rd2;
    id_imm = v.imm; id_pc  = v.pc;
    id_rs1 = v.rs1; id_rs2 = v.rs2; id_rd = v.rd;
    {id_regwrite, id_memread, id_memwrite,
     id_memtoreg, id_branch, id_alusrc} = v.ctl;
    id_aluop = v.aluop;
    id_valid = v.valid;
    flush    = fl;
  endtask

  task automatic push(bun_t v, logic cap, int ec);
    exp_t e;
    e.b    = cap ? v : '0;
    e.cnt  = ec[15:0];
    e.cnts = (ec > 3) ? 2'd3 : ec[1:0];
    q.push_back(e);
  endtask

  // one cycle: present v, check stall comb, queue post-edge state
  task automatic step(bun_t v, logic fl, logic es,
                      logic cap, int ec);
    @(negedge clk); #1;
    apply(v, fl);
    #1;
    chk("stall", {63'd0, stall}, {63'd0, es});
    chk("pc_write", {63'd0, pc_write}, {63'd0, !es});
    chk("if_id_write", {63'd0, if_id_write}, {63'd0, !es});
    push(v, cap, ec);
  endtask

  task automatic chk_reset_state(string tag);
    chk({tag, "_bundle_lo"}, dut_bun().rd1 | dut_bun().rd2, 64'd0);
    chk({tag, "_bundle_hi"}, dut_bun().imm | dut_bun().pc, 64'd0);
    chk({tag, "_ctl"}, {33'd0, dut_bun().rs1, dut_bun().rs2,
        dut_bun().rd, dut_bun().ctl, dut_bun().aluop,
        dut_bun().valid}, 64'd0);
    chk({tag, "_count"}, {46'd0, s_count, stall_count}, 64'd0);
    chk({tag, "_stall"}, {61'd0, stall, pc_write, if_id_write},
        64'd3);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      bun_t a;
      e = q.pop_front();
      a = dut_bun();
      chk("ex_rd1", a.rd1, e.b.rd1);
      chk("ex_rd2", a.rd2, e.b.rd2);
      chk("ex_imm", a.imm, e.b.imm);
      chk("ex_pc", a.pc, e.b.pc);
      chk("ex_idx", {49'd0, a.rs1, a.rs2, a.rd},
          {49'd0, e.b.rs1, e.b.rs2, e.b.rd});
      chk("ex_ctl", {55'd0, a.ctl, a.aluop, a.valid},
          {55'd0, e.b.ctl, e.b.aluop, e.b.valid});
      chk("stall_count", {48'd0, stall_count}, {48'd0, e.cnt});
      chk("stall_count_sat", {62'd0, s_count}, {62'd0, e.cnts});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1);
  end

  initial begin
    bun_t ld3, use3;
    apply('0, 1'b0);
    id_rd1 = 64'hdead; id_valid = 1'b1; id_memread = 1'b1;
    #3;
    chk_reset_state("reset_async");
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("reset_held");
    @(negedge clk); #1;
    reset = 1'b0;

    // plain pass-through, then an invalid decode slot
    step(mk(64'd16, 64'd36, 64'd7, 64'h1000, 5'd1, 5'd2,
            5'd5, C_ALU, 2'd2, 1'b1), 1'b0, 1'b0, 1'b1, 0);
    step(mk(64'h11, 64'h22, 64'h33, 64'h1004, 5'd5, 5'd6,
            5'd7, C_ALU, 2'd2, 1'b0), 1'b0, 1'b0, 1'b0, 0);

    // load-use on rs1: one bubble, then capture
    ld3  = mk(64'h100, 64'h0, 64'h8, 64'h1008, 5'd4, 5'd0,
              5'd3, C_LD, 2'd0, 1'b1);
    use3 = mk(64'h200, 64'h300, 64'h0, 64'h100c, 5'd3, 5'd8,
              5'd6, C_ALU, 2'd2, 1'b1);
    step(ld3, 1'b0, 1'b0, 1'b1, 0);
    step(use3, 1'b0, 1'b1, 1'b0, 1);
    step(use3, 1'b0, 1'b0, 1'b1, 1);

    // load-use on rs2 (store data)
    step(mk(64'h5, 64'h6, 64'h10, 64'h1010, 5'd2, 5'd0,
            5'd7, C_LD, 2'd0, 1'b1), 1'b0, 1'b0, 1'b1, 1);
    step(mk(64'h40, 64'h41, 64'h18, 64'h1014, 5'd1, 5'd7,
            5'd0, C_SD, 2'd0, 1'b1), 1'b0, 1'b1, 1'b0, 2);
    step(mk(64'h40, 64'h41, 64'h18, 64'h1014, 5'd1, 5'd7,
            5'd0, C_SD, 2'd0, 1'b1), 1'b0, 1'b0, 1'b1, 2);

    // load to x0 never stalls; ALU producer never stalls
    step(mk(64'h1, 64'h2, 64'h3, 64'h1018, 5'd4, 5'd0,
            5'd0, C_LD, 2'd0, 1'b1), 1'b0, 1'b0, 1'b1, 2);
    step(mk(64'h9, 64'ha, 64'h0, 64'h101c, 5'd0, 5'd0,
            5'd9, C_ALU, 2'd1, 1'b1), 1'b0, 1'b0, 1'b1, 2);
    step(mk(64'hb, 64'hc, 64'h0, 64'h1020, 5'd9, 5'd9,
            5'd10, C_ALU, 2'd3, 1'b1), 1'b0, 1'b0, 1'b1, 2);

    // flush with hazard present, then plain flush
    step(ld3, 1'b0, 1'b0, 1'b1, 2);
    step(use3, 1'b1, 1'b1, 1'b0, 2);
    step(use3, 1'b0, 1'b0, 1'b1, 2);
    step(use3, 1'b1, 1'b0, 1'b0, 2);

    // matching source but decode slot invalid
    step(ld3, 1'b0, 1'b0, 1'b1, 2);
    step(mk(64'h0, 64'h0, 64'h0, 64'h0, 5'd3, 5'd3,
            5'd1, C_ALU, 2'd2, 1'b0), 1'b0, 1'b0, 1'b0, 2);

    // five more stalls: 2-bit counter pins at 3
    for (int i = 0; i < 5; i++) begin
      step(mk(64'h70 + i, 64'h0, 64'h0, 64'h2000 + 8 * i,
              5'd1, 5'd0, 5'd10, C_LD, 2'd0, 1'b1),
           1'b0, 1'b0, 1'b1, 2 + i);
      step(mk(64'h0, 64'h80 + i, 64'h0, 64'h2004 + 8 * i,
              5'd2, 5'd10, 5'd11, C_ALU, 2'd2, 1'b1),
           1'b0, 1'b1, 1'b0, 3 + i);
    end

    // async reset while a load-use hazard is pending
    step(ld3, 1'b0, 1'b0, 1'b1, 7);
    @(negedge clk); #1;
    apply(use3, 1'b0);
    #1;
    chk("pre_reset_stall", {63'd0, stall}, 64'd1);
    chk("pre_reset_count", {48'd0, stall_count}, 64'd7);
    reset = 1'b1;
    #1;
    chk_reset_state("reset_mid");
    reset = 1'b0;
    push(use3, 1'b1, 0);
    step(mk(64'h55, 64'h66, 64'h77, 64'h3000, 5'd6, 5'd6,
            5'd12, C_ALU, 2'd1, 1'b1), 1'b0, 1'b0, 1'b1, 0);

    @(negedge clk); #1;
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter: DATA_W, 64, width of register-file read data, immediate and PC.
REQ-002 Parameter: CNT_W, 16, width of the load-use stall performance counter.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 id_rd1, id_rd2  input  DATA_W  operand values from the register-file read ports (RD1/RD2).
REQ-006 id_imm, id_pc  input  DATA_W  decoded immediate; PC of the decode-stage instruction.
REQ-007 id_rs1, id_rs2, id_rd  input  5  source and destination register indices.
REQ-008 id_regwrite, id_memread, id_memwrite, id_memtoreg, id_branch, id_alusrc  input  1  decode control bits.
REQ-009 id_aluop  input  2  ALU operation class.
REQ-010 id_valid  input  1  decode stage holds a real instruction.
REQ-011 flush  input  1  branch taken in EX; squash the instruction entering EX.
REQ-012 ex_rd1, ex_rd2, ex_imm, ex_pc  output  DATA_W  registered copies of the id_ equivalents.
REQ-013 ex_rs1, ex_rs2, ex_rd  output  5  registered indices.
REQ-014 ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch, ex_alusrc  output  1  registered control bits.
REQ-015 ex_aluop  output  2; ex_valid  output  1  registered ALU class and valid.
REQ-016 stall  output  1  combinational load-use hazard indication.
REQ-017 pc_write, if_id_write  output  1  both equal ~stall.
REQ-018 stall_count  output  CNT_W  number of stall bubbles inserted since reset.

Function
REQ-019 stall SHALL be 1 iff ex_valid & ex_memread & (ex_rd != 0) & id_valid & ((ex_rd == id_rs1) | (ex_rd == id_rs2)); else 0.
REQ-020 Register x0 SHALL never cause a stall (ex_rd == 0 masks the comparison).
REQ-021 On posedge clk with flush=1, the stage SHALL load a bubble regardless of stall.
REQ-022 On posedge clk with flush=0 and stall=1, the stage SHALL load a bubble.
REQ-023 On posedge clk with flush=0, stall=0, id_valid=1, all ex_ outputs SHALL take the id_ values; latency exactly 1 cycle.
REQ-024 On posedge clk with flush=0, stall=0, id_valid=0, the stage SHALL load a bubble.
REQ-025 Bubble: ex_valid and all ex_ control bits (regwrite, memread, memwrite, memtoreg, branch, alusrc) = 0, ex_aluop = 0, ex_rd/ex_rs1/ex_rs2 = 0, ex_rd1/ex_rd2/ex_imm/ex_pc = 0.
REQ-026 A single load-use hazard SHALL produce exactly one stall cycle, because the inserted bubble clears ex_memread.
REQ-027 stall_count SHALL increment by 1 on each posedge with stall=1 and flush=0; no increment when flush=1.
REQ-028 stall_count SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-029 Register-file write-back ordering (negedge write) is outside this block; operands are sampled as presented on id_rd1/id_rd2 at posedge.

Reset
REQ-030 While reset=1, all ex_ outputs and stall_count SHALL be 0 immediately (asynchronous), independent of clk.
REQ-031 Following from REQ-030, stall=0, pc_write=1, if_id_write=1 during reset.
REQ-032 Reset asserted mid-stall SHALL discard the pending bubble state; first posedge after deassertion captures normally per REQ-021..024.

Verification
REQ-033 Pass-through: id_valid=1, id_rd1=16, id_rd2=36, id_rd=5, id_regwrite=1, no hazard -> next cycle ex_rd1=16, ex_rd2=36, ex_rd=5, ex_regwrite=1, ex_valid=1.
REQ-034 Load-use: cycle N EX holds ld with ex_rd=3; ID has id_rs1=3 -> stall=1, pc_write=0 in N; ex_valid=0 in N+1; stall=0 in N+1; stall_count=1.
REQ-035 x0 masking: EX ld with ex_rd=0, ID id_rs2=0 -> stall=0, instruction captured next cycle, stall_count unchanged.
REQ-036 Flush and stall same cycle: hazard present and flush=1 -> bubble loaded, stall_count unchanged.
REQ-037 Async reset mid-operation: ex_valid=1, stall_count=7; pulse reset between edges -> all outputs 0 before next posedge; stall_count=0.
REQ-038 Saturation: CNT_W=2, force 5 consecutive load-use stalls -> stall_count reads 3 and holds.
